// File: rtl/tx_bytes.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_bytes: streams a ping-pong RAM frame to a byte serializer, CRC-16/MODBUS |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tx_bytes (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       user_crc,
   input  logic       abort,
   input  logic       unread,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_byte,
   output logic       switch,
   output logic [7:0] ser_data,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       ser_last,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_CRC_L = 3'd3;
   localparam logic [2:0] S_CRC_H = 3'd4;
   localparam logic [2:0] S_FIN   = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [7:0]  rd_addr_q, rd_addr_d;
   logic [7:0]  ser_data_q, ser_data_d;
   logic        ser_valid_q, ser_valid_d;
   logic        ser_last_q, ser_last_d;
   logic        switch_q, switch_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [15:0] crc_q, crc_d;
   logic [8:0]  idx_q, idx_d;
   logic [7:0]  len_q, len_d;

   logic        w_hs;
   logic [7:0]  w_len;
   logic [8:0]  w_last;
   logic [8:0]  w_idx_inc;
   logic        w_oversize;

   function automatic logic [15:0] crc_update(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      return r;
   endfunction

   // The length byte is being accepted at idx==2, so use it straight from ser_data.
   assign w_hs       = ser_valid_q & ser_ready;
   assign w_len      = (idx_q == 9'd2) ? ser_data_q : len_q;
   assign w_last     = user_crc ? ({1'b0, w_len} + 9'd4) : ({1'b0, w_len} + 9'd2);
   assign w_idx_inc  = idx_q + 9'd1;
   assign w_oversize = user_crc ? (ser_data_q > 8'd251) : (ser_data_q > 8'd253);

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      ser_data_d  = ser_data_q;
      ser_valid_d = ser_valid_q;
      ser_last_d  = ser_last_q;
      switch_d    = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      crc_d       = crc_q;
      idx_d       = idx_q;
      len_d       = len_q;

      case (state_q)
         S_IDLE: begin
            if (unread) begin
               rd_addr_d = 8'd0;
               idx_d     = 9'd0;
               crc_d     = 16'hFFFF;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            ser_data_d  = rd_byte;
            ser_valid_d = 1'b1;
            ser_last_d  = user_crc && (idx_q > 9'd2) && (idx_q == ({1'b0, len_q} + 9'd4));
            state_d     = S_SEND;
         end
         S_SEND: begin
            if (w_hs) begin
               crc_d       = crc_update(crc_q, ser_data_q);
               idx_d       = w_idx_inc;
               ser_valid_d = 1'b0;
               ser_last_d  = 1'b0;
               if (idx_q == 9'd2) begin
                  len_d = ser_data_q;
               end
               if ((idx_q == 9'd2) && w_oversize) begin
                  error_d  = 1'b1;
                  switch_d = 1'b1;
                  state_d  = S_IDLE;
               end else if ((idx_q >= 9'd2) && (idx_q == w_last)) begin
                  if (user_crc) begin
                     switch_d = 1'b1;
                     done_d   = 1'b1;
                     state_d  = S_FIN;
                  end else begin
                     state_d = S_CRC_L;
                  end
               end else begin
                  rd_addr_d = w_idx_inc[7:0];
                  state_d   = S_FETCH;
               end
            end
         end
         // CRC bytes use a load cycle then a present cycle, keeping the 2-clk byte gap.
         S_CRC_L: begin
            if (!ser_valid_q) begin
               ser_data_d  = crc_q[7:0];
               ser_valid_d = 1'b1;
            end else if (w_hs) begin
               ser_valid_d = 1'b0;
               state_d     = S_CRC_H;
            end
         end
         S_CRC_H: begin
            if (!ser_valid_q) begin
               ser_data_d  = crc_q[15:8];
               ser_valid_d = 1'b1;
               ser_last_d  = 1'b1;
            end else if (w_hs) begin
               ser_valid_d = 1'b0;
               ser_last_d  = 1'b0;
               switch_d    = 1'b1;
               done_d      = 1'b1;
               state_d     = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         ser_valid_d = 1'b0;
         ser_last_d  = 1'b0;
         switch_d    = 1'b0;
         done_d      = 1'b0;
         error_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         rd_addr_q   <= 8'd0;
         ser_data_q  <= 8'd0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
         switch_q    <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         crc_q       <= 16'hFFFF;
         idx_q       <= 9'd0;
         len_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         ser_data_q  <= ser_data_d;
         ser_valid_q <= ser_valid_d;
         ser_last_q  <= ser_last_d;
         switch_q    <= switch_d;
         done_q      <= done_d;
         error_q     <= error_d;
         crc_q       <= crc_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign ser_data  = ser_data_q;
   assign ser_valid = ser_valid_q;
   assign ser_last  = ser_last_q;
   assign switch    = switch_q;
   assign done      = done_q;
   assign error     = error_q;
   assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_bytes.sv
`default_nettype none
// Testbench for tx_bytes: scoreboard of expected serializer bytes against a byte monitor.
module tb_tx_bytes;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       user_crc = 1'b0;
   logic       abort = 1'b0;
   logic       unread = 1'b0;
   logic       ser_ready = 1'b1;
   logic [7:0] rd_addr;
   logic [7:0] rd_byte;
   logic [7:0] ser_data;
   logic       switch, ser_valid, ser_last, busy, done, error;

   logic [7:0] mem [0:255];
   logic [8:0] exp_q [$];
   logic [8:0] exp_item;
   int         n_tests = 0;
   int         n_fail = 0;
   int         n_switch = 0;
   int         n_done = 0;
   int         n_error = 0;
   int         max_addr = 0;
   bit         ready_rand = 1'b0;
   bit         hold_pend = 1'b0;
   logic [7:0] hold_data = 8'd0;

   always #5 clk = ~clk;
   assign rd_byte = mem[rd_addr];

   tx_bytes dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .user_crc  (user_crc),
      .abort     (abort),
      .unread    (unread),
      .rd_addr   (rd_addr),
      .rd_byte   (rd_byte),
      .switch    (switch),
      .ser_data  (ser_data),
      .ser_valid (ser_valid),
      .ser_ready (ser_ready),
      .ser_last  (ser_last),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Serializer model: ready either always high or toggling randomly.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         ser_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops one expected {last,data} per accepted byte; abort beats a handshake.
   always @(negedge clk) begin
      if (reset_n) begin
         if (hold_pend) begin
            check("hold_valid", 32'(ser_valid), 32'd1);
            check("hold_data", 32'(ser_data), 32'(hold_data));
         end
         hold_pend = ser_valid && !ser_ready && !abort;
         hold_data = ser_data;
         if (ser_valid && ser_ready && !abort) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_byte: got %0h, expected no byte", ser_data);
            end else begin
               exp_item = exp_q.pop_front();
               check("byte", 32'({ser_last, ser_data}), 32'(exp_item));
            end
         end
         if (switch) n_switch++;
         if (done)   n_done++;
         if (error)  n_error++;
         if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      end else begin
         hold_pend = 1'b0;
      end
   end

   // CRC-16/MODBUS over mem[0..n-1], fed one input bit at a time.
   function automatic logic [15:0] model_crc(input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++) begin
            if (c[0] ^ mem[i][b]) c = (c >> 1) ^ 16'hA001;
            else                  c = c >> 1;
         end
      end
      return c;
   endfunction

   task automatic fill(input int len, input bit uc, input int seed);
      logic [15:0] c;
      mem[0] = 8'(8'h50 + seed);
      mem[1] = 8'(8'hC3 ^ seed);
      mem[2] = 8'(len);
      for (int i = 0; i < len && (i + 3) < 256; i++) mem[i + 3] = 8'(i * 7 + seed * 13);
      if (uc) begin
         c = model_crc(len + 3);
         mem[len + 3] = c[7:0];
         mem[len + 4] = c[15:8];
      end
   endtask

   task automatic push_expected(input int len, input bit uc);
      logic [15:0] c;
      if (uc) begin
         for (int i = 0; i <= len + 4; i++) exp_q.push_back({(i == len + 4), mem[i]});
      end else begin
         for (int i = 0; i <= len + 2; i++) exp_q.push_back({1'b0, mem[i]});
         c = model_crc(len + 3);
         exp_q.push_back({1'b0, c[7:0]});
         exp_q.push_back({1'b1, c[15:8]});
      end
   endtask

   task automatic run_frame(input string name, input int exp_sw, input int exp_dn, input int exp_er);
      int  sw0, dn0, er0;
      bit  seen;
      sw0  = n_switch;
      dn0  = n_done;
      er0  = n_error;
      seen = 1'b0;
      unread = 1'b1;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (switch || error) seen = 1'b1;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no switch/error, expected one within 3000 cycles", name);
      end
      unread = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check({name, "_remaining"}, 32'(exp_q.size()), 32'd0);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_switch"}, 32'(n_switch - sw0), 32'(exp_sw));
      check({name, "_done"}, 32'(n_done - dn0), 32'(exp_dn));
      check({name, "_error"}, 32'(n_error - er0), 32'(exp_er));
      exp_q.delete();
   endtask

   initial begin
      int  sw0, dn0;
      bit  found;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_ser_data", 32'(ser_data), 32'd0);
      check("rst_ser_valid", 32'(ser_valid), 32'd0);
      check("rst_ser_last", 32'(ser_last), 32'd0);
      check("rst_switch", 32'(switch), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      abort = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      abort = 1'b0;
      check("idle_abort_busy", 32'(busy), 32'd0);

      // Appended CRC over 01 02 00 is 0x6021.
      user_crc = 1'b0;
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h00;
      exp_q.push_back(9'h001); exp_q.push_back(9'h002); exp_q.push_back(9'h000);
      exp_q.push_back(9'h021); exp_q.push_back(9'h160);
      run_frame("crc_append", 1, 1, 0);

      user_crc = 1'b1;
      mem[3] = 8'h21; mem[4] = 8'h60;
      exp_q.push_back(9'h001); exp_q.push_back(9'h002); exp_q.push_back(9'h000);
      exp_q.push_back(9'h021); exp_q.push_back(9'h160);
      run_frame("user_crc", 1, 1, 0);

      ready_rand = 1'b1;
      user_crc = 1'b0;
      fill(10, 1'b0, 3);
      push_expected(10, 1'b0);
      run_frame("rand_ready_uc0", 1, 1, 0);
      user_crc = 1'b1;
      fill(10, 1'b1, 9);
      push_expected(10, 1'b1);
      run_frame("rand_ready_uc1", 1, 1, 0);
      ready_rand = 1'b0;

      user_crc = 1'b0;
      mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hFE;
      exp_q.push_back(9'h0AA); exp_q.push_back(9'h0BB); exp_q.push_back(9'h0FE);
      run_frame("oversize_uc0", 1, 0, 1);

      user_crc = 1'b1;
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hFC;
      exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h0FC);
      run_frame("oversize_uc1", 1, 0, 1);

      fill(251, 1'b1, 4);
      push_expected(251, 1'b1);
      run_frame("max_uc1", 1, 1, 0);

      user_crc = 1'b0;
      max_addr = 0;
      fill(253, 1'b0, 6);
      push_expected(253, 1'b0);
      run_frame("max_uc0", 1, 1, 0);
      check("max_uc0_rd_addr", 32'(max_addr), 32'd255);

      // Abort while byte 5 is offered; the frame restarts from byte 0.
      fill(8, 1'b0, 5);
      push_expected(8, 1'b0);
      sw0 = n_switch;
      dn0 = n_done;
      found = 1'b0;
      unread = 1'b1;
      for (int k = 0; k < 200 && !found; k++) begin
         @(posedge clk);
         #1;
         if (ser_valid && rd_addr == 8'd5) found = 1'b1;
      end
      check("abort_reached_byte5", 32'(found), 32'd1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_valid", 32'(ser_valid), 32'd0);
      check("abort_last", 32'(ser_last), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      exp_q.delete();
      push_expected(8, 1'b0);
      run_frame("abort_resend", 1, 1, 0);
      check("abort_total_switch", 32'(n_switch - sw0), 32'd1);
      check("abort_total_done", 32'(n_done - dn0), 32'd1);

      // Reset mid-frame drops everything without a switch pulse.
      fill(20, 1'b0, 7);
      push_expected(20, 1'b0);
      sw0 = n_switch;
      dn0 = n_done;
      unread = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_valid", 32'(ser_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_rd_addr", 32'(rd_addr), 32'd0);
      unread = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("midrst_switch", 32'(n_switch - sw0), 32'd0);
      check("midrst_done", 32'(n_done - dn0), 32'd0);
      check("midrst_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tx_bytes.md
TX_BYTES -- requirements
Module: tx_bytes

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 user_crc  input  1  1: frame in RAM already ends with crc_l, crc_h; 0: block appends CRC.
REQ-004 abort  input  1  cancel current frame.
REQ-005 unread  input  1  pp_ram holds a complete frame ready to send.
REQ-006 rd_addr  output  8  pp_ram read address.
REQ-007 rd_byte  input  8  pp_ram data, valid one clk after rd_addr changes (synchronous RAM).
REQ-008 switch  output  1  one-clk pulse; releases the transmitted buffer.
REQ-009 ser_data  output  8  byte to serializer.
REQ-010 ser_valid  output  1  ser_data valid; held until accepted.
REQ-011 ser_ready  input  1  serializer accepts the byte when ser_valid && ser_ready.
REQ-012 ser_last  output  1  high with the final byte of the frame.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 done  output  1  one-clk pulse after the last byte is accepted.
REQ-015 error  output  1  one-clk pulse on an oversize frame.

Function
REQ-016 Frame format SHALL be: src, dst, len, data[len], crc_l, crc_h; total len+5 bytes.
REQ-017 FSM states SHALL be IDLE, FETCH, SEND, CRC_L, CRC_H, FIN.
REQ-018 IDLE: when unread=1, set rd_addr=0, idx=0, crc=0xFFFF, and go to FETCH.
REQ-019 FETCH (one clk): on the next clk, load ser_data<=rd_byte, set ser_valid=1, go to SEND.
REQ-020 SEND: on handshake, crc<=crc_update(crc, ser_data); if idx==2, latch len<=ser_data; idx increments (9-bit).
REQ-021 After the handshake, if idx==last, go to CRC_L when user_crc=0 or FIN when user_crc=1; otherwise rd_addr<=idx+1, go to FETCH, ser_valid<=0.
REQ-022 last SHALL be len+2 when user_crc=0 and len+4 when user_crc=1, computed 9-bit; for idx<2 it is not compared.
REQ-023 CRC SHALL be CRC-16/MODBUS: reflected poly 0xA001, init 0xFFFF, 8 bit-steps per byte in a single clk, no final XOR.
REQ-024 CRC_L: present crc[7:0]; on handshake go to CRC_H. CRC_H: present crc[15:8] with ser_last=1; on handshake go to FIN.
REQ-025 With user_crc=1, ser_last SHALL be high with the RAM byte at idx==len+4.
REQ-026 FIN: pulse switch=1 and done=1 for one clk, go to IDLE.
REQ-027 Byte-to-byte gap SHALL be 2 clk minimum (FETCH + SEND); ser_data SHALL stay stable while ser_valid=1 and ser_ready=0.
REQ-028 Oversize: at the idx==2 handshake, if len>253 (user_crc=0) or len>251 (user_crc=1), pulse error, pulse switch, drop ser_valid, and go to IDLE; no done.
REQ-029 abort in any non-IDLE state: next clk go to IDLE with ser_valid=0 and ser_last=0; no switch and no done; abort wins over a simultaneous handshake.
REQ-030 abort in IDLE SHALL be ignored; unread sampled only in IDLE.
REQ-031 len=0: exactly 5 bytes; ser_last on byte 4.

Reset
REQ-032 On reset_n=0: state=IDLE; rd_addr=0, ser_data=0, ser_valid=0, ser_last=0, switch=0, done=0, error=0, busy=0; crc=0xFFFF, idx=0, len=0.
REQ-033 Reset mid-frame SHALL abandon the frame without a switch pulse.

Verification
REQ-034 user_crc=0, RAM 01 02 00, ser_ready=1 -> ser bytes 01 02 00 21 60; ser_last on 0x60; one switch and one done pulse.
REQ-035 user_crc=1, RAM 01 02 00 21 60 -> same 5 bytes output verbatim; no CRC appended; ser_last on 0x60.
REQ-036 ser_ready toggling 0/1 randomly, len=10 -> 15 bytes, each held stable until accepted, ordering intact.
REQ-037 user_crc=0, len=0xFE -> 3 bytes sent, error pulse, switch pulse, no done, busy=0 afterwards.
REQ-038 abort asserted on byte 5 of a len=8 frame -> ser_valid=0 next clk, no switch/done; frame resent from byte 0 while unread=1.
REQ-039 len=253, user_crc=0 -> rd_addr reaches 255, 258 bytes sent, CRC correct.
